// File: rtl/bft_pkg.sv
// Shared types and lane arithmetic for the butterfly transform engine.
// Samples are {real, imag}, with each lane LANE_W bits wide.
package bft_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANE_W = DATA_W / 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_A    = 3'd1,
        LOAD_B    = 3'd2,
        PUSH_SUM  = 3'd3,
        PUSH_DIFF = 3'd4
    } bftState_e;

    // Per-lane wrap-around arithmetic; no carry crosses between the lanes.
    function automatic logic [DATA_W-1:0] laneAdd(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [LANE_W-1:0] re;
        logic [LANE_W-1:0] im;
        re = a[DATA_W-1:LANE_W] + b[DATA_W-1:LANE_W];
        im = a[LANE_W-1:0] + b[LANE_W-1:0];
        return {re, im};
    endfunction

    function automatic logic [DATA_W-1:0] laneSub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [LANE_W-1:0] re;
        logic [LANE_W-1:0] im;
        re = a[DATA_W-1:LANE_W] - b[DATA_W-1:LANE_W];
        im = a[LANE_W-1:0] - b[LANE_W-1:0];
        return {re, im};
    endfunction

endpackage

// File: rtl/bft_fifo.sv
// Synchronous FIFO with a first-word-fall-through head.
// A push while full is only accepted when a pop frees the slot in the same cycle.
module bft_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       wbClk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wrPtr_r;
    logic [AW-1:0]    rdPtr_r;
    logic [AW:0]      count_r;
    logic             doPush_s;
    logic             doPop_s;

    assign empty    = (count_r == {(AW+1){1'b0}});
    assign full     = (count_r == FULL_CNT);
    assign count    = count_r;
    assign dout     = mem_r[rdPtr_r];
    assign doPop_s  = pop && !empty;
    assign doPush_s = push && (!full || doPop_s);

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge wbClk) begin
        if (doPush_s) begin
            mem_r[wrPtr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge wbClk or negedge reset) begin
        if (!reset) begin
            wrPtr_r <= {AW{1'b0}};
            rdPtr_r <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else begin
            if (doPush_s) begin
                wrPtr_r <= wrPtr_r + 1'b1;
            end
            if (doPop_s) begin
                rdPtr_r <= rdPtr_r + 1'b1;
            end
            case ({doPush_s, doPop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/bft_core.sv
// Butterfly engine: pairs consecutive input samples (A, B) and emits A+B then A-B.
// Input words arriving at a full input FIFO are dropped and latch the error flag.
module bft_core
    import bft_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int IN_DEPTH   = 16,
    parameter int OUT_DEPTH  = 16
) (
    input  logic                  wbClk,
    input  logic                  reset,
    input  logic                  wbDataForInput,
    input  logic [DATA_WIDTH-1:0] wbInputData,
    input  logic                  wbWriteOut,
    output logic                  wbDataForOutput,
    output logic [DATA_WIDTH-1:0] wbOutputData,
    output logic                  error
);

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam logic [IAW:0] IN_MIN    = (IAW+1)'(2);
    localparam logic [OAW:0] OUT_LIMIT = (OAW+1)'(OUT_DEPTH - 2);

    bftState_e             state_r;
    bftState_e             nextState_s;
    logic [DATA_WIDTH-1:0] capA_r;
    logic [DATA_WIDTH-1:0] capB_r;

    logic                  inPush_s;
    logic                  inPop_s;
    logic [DATA_WIDTH-1:0] inDout_s;
    logic [IAW:0]          inCount_s;
    logic                  inFull_s;
    logic                  inEmpty_s;
    logic                  drop_s;

    logic                  outPush_s;
    logic                  outPop_s;
    logic [DATA_WIDTH-1:0] outDin_s;
    logic [DATA_WIDTH-1:0] outDout_s;
    logic [OAW:0]          outCount_s;
    logic                  outFull_s;
    logic                  outEmpty_s;
    logic                  startPair_s;

    assign inPush_s    = wbDataForInput && (!inFull_s || inPop_s);
    assign drop_s      = wbDataForInput && inFull_s && !inPop_s;
    assign outPop_s    = wbWriteOut && !outEmpty_s;
    // Two free output slots guarantee the sum/diff pushes can never overflow.
    assign startPair_s = (inCount_s >= IN_MIN) && (outCount_s <= OUT_LIMIT);

    bft_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) inFifo (
        .wbClk (wbClk),
        .reset (reset),
        .push  (inPush_s),
        .pop   (inPop_s),
        .din   (wbInputData),
        .dout  (inDout_s),
        .count (inCount_s),
        .full  (inFull_s),
        .empty (inEmpty_s)
    );

    bft_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(OUT_DEPTH)) outFifo (
        .wbClk (wbClk),
        .reset (reset),
        .push  (outPush_s),
        .pop   (outPop_s),
        .din   (outDin_s),
        .dout  (outDout_s),
        .count (outCount_s),
        .full  (outFull_s),
        .empty (outEmpty_s)
    );

    // Next-state and datapath strobes of the pairing FSM.
    always_comb begin
        nextState_s = state_r;
        inPop_s     = 1'b0;
        outPush_s   = 1'b0;
        outDin_s    = {DATA_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (startPair_s) begin
                    nextState_s = LOAD_A;
                end else begin
                    nextState_s = IDLE;
                end
            end
            LOAD_A: begin
                inPop_s     = 1'b1;
                nextState_s = LOAD_B;
            end
            LOAD_B: begin
                inPop_s     = 1'b1;
                nextState_s = PUSH_SUM;
            end
            PUSH_SUM: begin
                outPush_s   = 1'b1;
                outDin_s    = laneAdd(capA_r, capB_r);
                nextState_s = PUSH_DIFF;
            end
            PUSH_DIFF: begin
                outPush_s   = 1'b1;
                outDin_s    = laneSub(capA_r, capB_r);
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State register and A/B operand capture from the input FIFO head.
    always_ff @(posedge wbClk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            capA_r  <= {DATA_WIDTH{1'b0}};
            capB_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= nextState_s;
            case (state_r)
                LOAD_A:  capA_r <= inDout_s;
                LOAD_B:  capB_r <= inDout_s;
                default: capA_r <= capA_r;
            endcase
        end
    end

    // Registered host-side outputs; read data holds between valid pulses.
    always_ff @(posedge wbClk or negedge reset) begin
        if (!reset) begin
            wbDataForOutput <= 1'b0;
            wbOutputData    <= {DATA_WIDTH{1'b0}};
            error           <= 1'b0;
        end else begin
            wbDataForOutput <= outPop_s;
            if (outPop_s) begin
                wbOutputData <= outDout_s;
            end
            error <= error | drop_s;
        end
    end

endmodule

// File: tb/tb_bft_core.sv
// Directed bench for bft_core: expected words are queued when stimulus is issued
// and a forked monitor compares them against each output valid pulse.
`timescale 1ns/1ps
module tb_bft_core;

    logic        wbClk = 1'b0;
    logic        reset = 1'b0;
    logic        wbDataForInput = 1'b0;
    logic [31:0] wbInputData = 32'h0;
    logic        wbWriteOut = 1'b0;
    logic        wbDataForOutput;
    logic [31:0] wbOutputData;
    logic        error;

    int          total = 0;
    int          bad = 0;
    int          rxCount = 0;
    logic [31:0] expQ[$];

    bft_core #(.DATA_WIDTH(32), .IN_DEPTH(16), .OUT_DEPTH(16)) dut (
        .wbClk           (wbClk),
        .reset           (reset),
        .wbDataForInput  (wbDataForInput),
        .wbInputData     (wbInputData),
        .wbWriteOut      (wbWriteOut),
        .wbDataForOutput (wbDataForOutput),
        .wbOutputData    (wbOutputData),
        .error           (error)
    );

    always #5 wbClk = ~wbClk;

    function automatic logic [31:0] refSum(input logic [31:0] a, input logic [31:0] b);
        logic [15:0] r;
        logic [15:0] i;
        r = a[31:16] + b[31:16];
        i = a[15:0] + b[15:0];
        return {r, i};
    endfunction

    function automatic logic [31:0] refDiff(input logic [31:0] a, input logic [31:0] b);
        logic [15:0] r;
        logic [15:0] i;
        r = a[31:16] - b[31:16];
        i = a[15:0] - b[15:0];
        return {r, i};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic expectPair(input logic [31:0] a, input logic [31:0] b);
        expQ.push_back(refSum(a, b));
        expQ.push_back(refDiff(a, b));
    endtask

    task automatic monitorLoop();
        forever begin
            @(negedge wbClk);
            if (wbDataForOutput === 1'b1) begin
                rxCount++;
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h want none", wbOutputData);
                end else begin
                    check("output", wbOutputData, expQ.pop_front());
                end
            end
        end
    endtask

    task automatic drive(input logic [31:0] w);
        @(negedge wbClk);
        wbDataForInput = 1'b1;
        wbInputData    = w;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge wbClk);
            wbDataForInput = 1'b0;
        end
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge wbClk);
            n++;
        end
        repeat (6) @(negedge wbClk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: pending=%0d want 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        int          base;
        logic [31:0] acc[$];
        logic [31:0] w;
        logic [31:0] v;

        fork
            monitorLoop();
        join_none

        // Reset state
        repeat (10) @(negedge wbClk);
        reset = 1'b1;
        @(negedge wbClk);
        check("reset_valid", {31'd0, wbDataForOutput}, 32'd0);
        check("reset_data", wbOutputData, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        wbWriteOut = 1'b1;
        repeat (10) @(negedge wbClk);
        check("empty_read_pulses", rxCount, 32'd0);
        check("empty_read_error", {31'd0, error}, 32'd0);

        // Basic pair
        expQ.push_back(32'h00040003);
        expQ.push_back(32'h0002FFFF);
        drive(32'h00030001);
        drive(32'h00010002);
        idle(1);
        waitDrain("basic", 40);

        // Lane wrap-around
        expQ.push_back(32'hFFFEFFFD);
        expQ.push_back(32'h00000001);
        drive(32'hFFFFFFFF);
        drive(32'hFFFFFFFE);
        idle(1);
        waitDrain("wrap", 40);

        // Odd sample count: third word waits for its partner
        base = rxCount;
        expQ.push_back(32'h00150023);
        expQ.push_back(32'h000B001D);
        drive(32'h00100020);
        drive(32'h00050003);
        drive(32'h01000200);
        idle(1);
        waitDrain("odd_first", 40);
        idle(30);
        check("odd_held_count", rxCount - base, 32'd2);
        expQ.push_back(32'h01FF0201);
        expQ.push_back(32'h000101FF);
        drive(32'h00FF0001);
        idle(1);
        waitDrain("odd_second", 40);
        check("odd_total_count", rxCount - base, 32'd4);

        // Streaming bursts of 8 decrementing words every 26 cycles
        base = rxCount;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k += 2) begin
                expectPair(32'd0 - 32'(b * 8 + k), 32'd0 - 32'(b * 8 + k + 1));
            end
            for (int k = 0; k < 8; k++) begin
                drive(32'd0 - 32'(b * 8 + k));
            end
            idle(18);
        end
        waitDrain("stream", 200);
        check("stream_count", rxCount - base, 32'd32);
        check("stream_error", {31'd0, error}, 32'd0);

        // Overflow: 40 back-to-back words with no reads; words 26,27,30-32,35-37 drop
        wbWriteOut = 1'b0;
        idle(10);
        for (int i = 0; i < 40; i++) begin
            w = {16'(i) + 16'h7FF0, 16'h0010 - 16'(i)};
            if (!(i == 26 || i == 27 || (i >= 30 && i <= 32) || (i >= 35 && i <= 37))) begin
                acc.push_back(w);
            end
        end
        for (int p = 0; p < acc.size(); p += 2) begin
            expectPair(acc[p], acc[p+1]);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge wbClk);
            if (i == 26) check("error_before_drop", {31'd0, error}, 32'd0);
            if (i == 27) check("error_first_drop", {31'd0, error}, 32'd1);
            wbDataForInput = 1'b1;
            wbInputData    = {16'(i) + 16'h7FF0, 16'h0010 - 16'(i)};
        end
        idle(20);
        check("overflow_no_reads", rxCount - base, 32'd32);
        base = rxCount;
        wbWriteOut = 1'b1;
        waitDrain("overflow", 400);
        check("overflow_count", rxCount - base, 32'd32);
        check("error_sticky", {31'd0, error}, 32'd1);

        // Only reset clears the sticky error
        @(negedge wbClk);
        reset = 1'b0;
        repeat (3) @(negedge wbClk);
        check("error_reset", {31'd0, error}, 32'd0);
        v = wbOutputData;
        check("reset_data_again", v, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge wbClk);
        check("post_reset_valid", {31'd0, wbDataForOutput}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
